// File: rtl/alu_pkg.sv
// Shared ALU constants: gate reset default and bit positions inside the packed {p,q,r} vector.
package alu_pkg;

  localparam logic [2:0] GATE_RST_DEFAULT = 3'b000;

  localparam int P_IDX = 2;
  localparam int Q_IDX = 1;
  localparam int R_IDX = 0;

endpackage : alu_pkg

// File: rtl/three_input_gate_if.sv
// Operand/result bundle for the 3-input gate; the gate is the slave, the operand source is the master.
interface three_input_gate_if;

  logic a;
  logic b;
  logic c;
  logic p;
  logic q;
  logic r;

  modport master (output a, output b, output c, input p, input q, input r);
  modport slave  (input a, input b, input c, output p, output q, output r);

endinterface : three_input_gate_if

// File: rtl/gate3_core.sv
// 3-input AND / OR / odd-parity, purely combinational, zero latency, no flow control.
module gate3_core (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p_n,
  output logic q_n,
  output logic r_n
);

  assign p_n = a & b & c;
  assign q_n = a | b | c;
  assign r_n = a ^ b ^ c;

endmodule : gate3_core

// File: rtl/three_input_gate.sv
// 3-input AND/OR/parity gate; 1-cycle registered (OUT_REG=1) or combinational (OUT_REG=0).
// No handshake: every cycle is valid and the gate never stalls.
module three_input_gate
  import alu_pkg::*;
#(
  parameter bit         OUT_REG = 1'b1,
  parameter logic [2:0] RST_VAL = GATE_RST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  three_input_gate_if.slave  gate
);

  logic       w_p_n;
  logic       w_q_n;
  logic       w_r_n;
  logic [2:0] w_pqr_n;
  logic [2:0] w_pqr;

  gate3_core u_core (
    .a   (gate.a),
    .b   (gate.b),
    .c   (gate.c),
    .p_n (w_p_n),
    .q_n (w_q_n),
    .r_n (w_r_n)
  );

  always_comb begin
    w_pqr_n        = '0;
    w_pqr_n[P_IDX] = w_p_n;
    w_pqr_n[Q_IDX] = w_q_n;
    w_pqr_n[R_IDX] = w_r_n;
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [2:0] r_pqr;

      // Reset wins over the operands sampled on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pqr <= RST_VAL;
        end else begin
          r_pqr <= w_pqr_n;
        end
      end

      assign w_pqr = r_pqr;
    end else begin : g_comb
      logic w_unused_clk_rst;

      assign w_unused_clk_rst = clk ^ rst;
      assign w_pqr            = w_pqr_n;
    end
  endgenerate

  assign gate.p = w_pqr[P_IDX];
  assign gate.q = w_pqr[Q_IDX];
  assign gate.r = w_pqr[R_IDX];

endmodule : three_input_gate

// File: tb/tb_three_input_gate.sv
// Directed + random checks of the registered and combinational gate builds against a hand-written truth table.
module tb_three_input_gate;

  logic clk;
  logic rst;
  logic clk_c;
  logic rst_c;

  int errs;
  int checks;

  logic [2:0] tt [8];

  three_input_gate_if gif_reg ();
  three_input_gate_if gif_comb ();

  three_input_gate #(.OUT_REG(1'b1), .RST_VAL(3'b000)) u_dut_reg (
    .clk  (clk),
    .rst  (rst),
    .gate (gif_reg)
  );

  three_input_gate #(.OUT_REG(1'b0), .RST_VAL(3'b000)) u_dut_comb (
    .clk  (clk_c),
    .rst  (rst_c),
    .gate (gif_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive_reg(input logic [2:0] v);
    gif_reg.a = v[2];
    gif_reg.b = v[1];
    gif_reg.c = v[0];
  endtask

  task automatic drive_comb(input logic [2:0] v);
    gif_comb.a = v[2];
    gif_comb.b = v[1];
    gif_comb.c = v[0];
  endtask

  function automatic logic [2:0] out_reg();
    return {gif_reg.p, gif_reg.q, gif_reg.r};
  endfunction

  function automatic logic [2:0] out_comb();
    return {gif_comb.p, gif_comb.q, gif_comb.r};
  endfunction

  initial begin
    logic [2:0] v;
    logic [2:0] o;

    errs   = 0;
    checks = 0;

    tt[0] = 3'b000;
    tt[1] = 3'b011;
    tt[2] = 3'b011;
    tt[3] = 3'b010;
    tt[4] = 3'b011;
    tt[5] = 3'b010;
    tt[6] = 3'b010;
    tt[7] = 3'b111;

    clk_c = 1'b0;
    rst_c = 1'b1;
    drive_comb(3'b000);

    // Reset held two cycles with all operands high.
    rst = 1'b1;
    drive_reg(3'b111);
    @(posedge clk); #1;
    chk("rst_edge1", out_reg(), 3'b000);
    @(posedge clk); #1;
    chk("rst_edge2", out_reg(), 3'b000);

    // Exhaustive sweep, one vector per cycle.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive_reg(v);
      @(posedge clk); #1;
      chk($sformatf("sweep_%0d", i), out_reg(), tt[i]);
    end

    // Latency and between-edge glitch invisibility.
    drive_reg(3'b000);
    @(posedge clk); #1;
    chk("lat_base", out_reg(), 3'b000);
    #1 drive_reg(3'b111);
    #1 chk("lat_hold", out_reg(), 3'b000);
    #1 drive_reg(3'b001);
    #1 chk("glitch_hold", out_reg(), 3'b000);
    #1 drive_reg(3'b111);
    @(posedge clk); #1;
    chk("lat_next", out_reg(), 3'b111);

    // Reset mid-stream overrides the operands on that edge.
    drive_reg(3'b100);
    @(posedge clk); #1;
    chk("mid_pre", out_reg(), 3'b011);
    rst = 1'b1;
    drive_reg(3'b101);
    @(posedge clk); #1;
    chk("mid_rst", out_reg(), 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_post", out_reg(), 3'b010);

    // Combinational build: no clock on its instance, reset held high.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive_comb(v);
      #1;
      chk($sformatf("comb_%0d", i), out_comb(), tt[i]);
    end

    // Random operands: full result, implication, parity and X checks.
    for (int n = 0; n < 1000; n++) begin
      v = 3'($urandom_range(0, 7));
      drive_reg(v);
      @(posedge clk); #1;
      o = out_reg();
      chk("rnd_noX", {2'b00, $isunknown(o)}, 3'b000);
      chk("rnd_p_imp_q", {2'b00, o[2] & ~o[1]}, 3'b000);
      chk("rnd_parity", {2'b00, o[0]}, {2'b00, ^v});
      chk("rnd_tt", o, tt[v]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_three_input_gate
